// File: rtl/fetch_phase_const_collector_pkg.sv
// fetch_phase_const_collector_pkg: shared kinds, sizes, states and sign-extension for fetch-phase constants
package fetch_phase_const_collector_pkg;
    localparam int DEF_VAL_W = 64;
    localparam int DEF_MAX_BYTES = DEF_VAL_W / 8;

    typedef enum logic {
        KIND_DISP = 1'b0,
        KIND_IMM  = 1'b1
    } fetch_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    function automatic logic size_legal(input logic [3:0] s);
        return s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8;
    endfunction

    function automatic logic [DEF_VAL_W-1:0] sign_extend(input logic [DEF_VAL_W-1:0] s, input logic [3:0] size);
        return size == 4'd1 ? {{56{s[7]}}, s[7:0]} :
               size == 4'd2 ? {{48{s[15]}}, s[15:0]} :
               size == 4'd4 ? {{32{s[31]}}, s[31:0]} : s;
    endfunction
endpackage

// File: rtl/fetch_const_sext.sv
// fetch_const_sext: sign-extends a little-endian byte store from bit 8*size-1 to the full constant width
module fetch_const_sext
    import fetch_phase_const_collector_pkg::*;
(
    input  logic [DEF_VAL_W-1:0] store,
    input  logic [3:0]           size,
    output logic [DEF_VAL_W-1:0] value
);
    assign value = sign_extend(store, size);
endmodule

// File: rtl/fetch_phase_const_collector.sv
// fetch_phase_const_collector: collects 1/2/4/8 fetch bytes into a sign-extended constant.
// FETCH_CONST_BYPASS_EN: present the constant combinationally in the cycle its last byte arrives.
module fetch_phase_const_collector
    import fetch_phase_const_collector_pkg::*;
#(
    parameter int VAL_W = DEF_VAL_W,
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             start,
    output logic             start_ready,
    input  logic [3:0]       start_size,
    input  logic             start_kind,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [7:0]       byte_data,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [VAL_W-1:0] done_value,
    output logic             done_kind,
    output logic             size_err
);
    localparam int CW = $clog2(MAX_BYTES);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [VAL_W-1:0] store, store_nxt, sext_in, sext_out;
    logic [3:0]       size_q;
    fetch_kind_e      kind_q;
    logic             hold, accept, last, fin_now;

    assign hold = state == HOLD;
    assign byte_ready = state == COLLECT;
    assign start_ready = state == IDLE || (hold && done_ready);
    assign accept = byte_ready && byte_valid;
    assign last = accept && (4'(cnt) == size_q - 4'd1);

    always_comb begin
        store_nxt = store;
        store_nxt[8*cnt +: 8] = byte_data;
    end

`ifdef FETCH_CONST_BYPASS_EN
    assign fin_now = last;
    assign sext_in = hold ? store : store_nxt;
`else
    assign fin_now = 1'b0;
    assign sext_in = store;
`endif

    // flush hides the pending constant so a same-cycle done_ready cannot take it
    assign done_valid = (hold || fin_now) && !flush;
    assign done_value = done_valid ? sext_out : '0;
    assign done_kind = kind_q;

    fetch_const_sext u_sext (
        .store(sext_in),
        .size (size_q),
        .value(sext_out)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            store <= '0;
            size_q <= 4'd0;
            kind_q <= KIND_DISP;
            size_err <= 1'b0;
        end else begin
            size_err <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt <= '0;
            end else if (start && start_ready) begin
                if (size_legal(start_size)) begin
                    state <= COLLECT;
                    size_q <= start_size;
                    kind_q <= fetch_kind_e'(start_kind);
                    cnt <= '0;
                    store <= '0;
                end else begin
                    state <= IDLE;
                    size_err <= 1'b1;
                end
            end else if (hold && done_ready) begin
                state <= IDLE;
            end else if (accept) begin
                store <= store_nxt;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) state <= (fin_now && done_ready) ? IDLE : HOLD;
            end
        end
    end
endmodule

// File: tb/tb_fetch_phase_const_collector.sv
// tb_fetch_phase_const_collector: directed vectors with hand-computed constants for the fetch constant collector
module tb_fetch_phase_const_collector;
    logic        clk = 1'b0;
    logic        rstn, flush, start, start_kind, byte_valid, done_ready;
    logic [3:0]  start_size;
    logic [7:0]  byte_data;
    logic        start_ready, byte_ready, done_valid, done_kind, size_err;
    logic [63:0] done_value;
    logic [31:0] w4 = 32'h12345678;
    int          checks = 0;
    int          errors = 0;

`ifdef FETCH_CONST_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    fetch_phase_const_collector dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .start(start), .start_ready(start_ready), .start_size(start_size), .start_kind(start_kind),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_value(done_value),
        .done_kind(done_kind), .size_err(size_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; start = 1'b0; start_size = 4'd0; start_kind = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00; done_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_value", done_value, 0);
        chk("rst_done_kind", done_kind, 0);
        chk("rst_size_err", size_err, 0);
        rstn = 1'b1;
        tick();

        // size 4 displacement, little-endian assembly and one-cycle latency
        start = 1'b1; start_size = 4'd4; start_kind = 1'b0;
        @(negedge clk); chk("t1_start_ready", start_ready, 1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = w4[8*i +: 8];
            @(negedge clk);
            chk("t1_byte_ready", byte_ready, 1);
            chk("t1_start_ready_busy", start_ready, 0);
            chk("t1_early_valid", done_valid, (i == 3) ? 64'(BYP) : 64'd0);
            tick();
        end
        byte_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk);
        chk("t1_done_valid", done_valid, 1);
        chk("t1_value", done_value, 64'h0000_0000_1234_5678);
        chk("t1_kind", done_kind, 0);
        chk("t1_hold_byte_ready", byte_ready, 0);
        tick();
        done_ready = 1'b0;

        // size 1 immediate, stalled consumer
        start = 1'b1; start_size = 4'd1; start_kind = 1'b1;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h80;
        @(negedge clk); tick();
        byte_data = 8'h99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_value", done_value, 64'hFFFF_FFFF_FFFF_FF80);
            chk("t2_valid", done_valid, 1);
            chk("t2_byte_ready", byte_ready, 0);
            chk("t2_kind", done_kind, 1);
            tick();
        end
        byte_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk); chk("t2_value_last", done_value, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        done_ready = 1'b0;
        @(negedge clk);
        chk("t2_idle_start_ready", start_ready, 1);
        chk("t2_idle_valid", done_valid, 0);
        tick();

        // size 8 with gaps in the byte stream
        start = 1'b1; start_size = 4'd8; start_kind = 1'b0;
        @(negedge clk); tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_data = 8'(i + 1);
            @(negedge clk); tick();
            byte_valid = 1'b0; byte_data = 8'hEE;
            @(negedge clk);
            if (i < 7) chk("t3_collecting", byte_ready, 1);
            tick();
        end
        done_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid", done_valid, 1);
        chk("t3_value", done_value, 64'h0807_0605_0403_0201);
        tick();
        done_ready = 1'b0;

        // displacement followed by immediate with no bubble
        start = 1'b1; start_size = 4'd1; start_kind = 1'b0;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h10;
        @(negedge clk); tick();
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t4_hold_start_ready", start_ready, 0);
        chk("t4_value_a", done_value, 64'h10);
        tick();
        done_ready = 1'b1; start = 1'b1; start_size = 4'd2; start_kind = 1'b1;
        @(negedge clk);
        chk("t4_chain_ready", start_ready, 1);
        chk("t4_chain_value", done_value, 64'h10);
        chk("t4_chain_kind", done_kind, 0);
        tick();
        done_ready = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_data = 8'hFE;
        @(negedge clk);
        chk("t4_collect_b", byte_ready, 1);
        chk("t4_valid_off", done_valid, 0);
        tick();
        byte_data = 8'hFF;
        @(negedge clk); tick();
        byte_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk);
        chk("t4_value_b", done_value, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t4_kind_b", done_kind, 1);
        tick();
        done_ready = 1'b0;

        // flush abandons a partial constant
        start = 1'b1; start_size = 4'd4; start_kind = 1'b0;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h11;
        @(negedge clk); tick();
        byte_data = 8'h22;
        @(negedge clk); tick();
        flush = 1'b1; byte_data = 8'h33;
        @(negedge clk); chk("t5_flush_valid", done_valid, 0);
        tick();
        flush = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        chk("t5_idle_start_ready", start_ready, 1);
        chk("t5_idle_byte_ready", byte_ready, 0);
        tick();
        start = 1'b1; start_size = 4'd2;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h34;
        @(negedge clk); tick();
        byte_data = 8'h12;
        @(negedge clk); tick();
        byte_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid", done_valid, 1);
        chk("t5_value", done_value, 64'h1234);
        tick();
        done_ready = 1'b0;

        // illegal sizes
        start = 1'b1; start_size = 4'd3; byte_valid = 1'b1; byte_data = 8'h77;
        @(negedge clk); chk("t6_err_pre", size_err, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t6_err_pulse", size_err, 1);
        chk("t6_stay_idle", start_ready, 1);
        chk("t6_no_byte", byte_ready, 0);
        tick();
        byte_valid = 1'b0;
        @(negedge clk); chk("t6_err_clear", size_err, 0);
        tick();
        start = 1'b1; start_size = 4'd0;
        @(negedge clk); tick();
        start = 1'b0;
        @(negedge clk); chk("t6_err_size0", size_err, 1);
        tick();

        // flush during HOLD discards even with done_ready
        start = 1'b1; start_size = 4'd1; start_kind = 1'b0;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h55;
        @(negedge clk); tick();
        byte_valid = 1'b0; done_ready = 1'b1; flush = 1'b1;
        @(negedge clk); chk("t7_flush_hold_valid", done_valid, 0);
        tick();
        flush = 1'b0; done_ready = 1'b0;
        @(negedge clk);
        chk("t7_idle", start_ready, 1);
        chk("t7_gone", done_valid, 0);
        tick();

        // size 2 with consumer ready on the last byte
        start = 1'b1; start_size = 4'd2; start_kind = 1'b1;
        @(negedge clk); tick();
        start = 1'b0; done_ready = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
        @(negedge clk); tick();
        byte_data = 8'hBB;
        @(negedge clk);
        chk("t8_same_cycle_valid", done_valid, 64'(BYP));
        if (BYP) chk("t8_bypass_value", done_value, 64'hFFFF_FFFF_FFFF_BBAA);
        tick();
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t8_next_valid", done_valid, 64'(!BYP));
        chk("t8_next_value", done_value, BYP ? 64'd0 : 64'hFFFF_FFFF_FFFF_BBAA);
        tick();
        done_ready = 1'b0;

        // asynchronous reset mid-collection
        start = 1'b1; start_size = 4'd4; start_kind = 1'b1;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'h01;
        @(negedge clk); tick();
        byte_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("t9_async_byte_ready", byte_ready, 0);
        chk("t9_async_start_ready", start_ready, 1);
        chk("t9_async_kind", done_kind, 0);
        rstn = 1'b1;
        tick();
        start = 1'b1; start_size = 4'd1; start_kind = 1'b0;
        @(negedge clk); tick();
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'hFF;
        @(negedge clk); tick();
        byte_valid = 1'b0; done_ready = 1'b1;
        @(negedge clk); chk("t9_after_reset_value", done_value, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        done_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
